riscv_v_logic_seq: RTL

//   Sequencer for the vector bitwise-logic datapath (vand/vor/vxor/vmv, SEW=8).

---
 rtl/riscv_v_logic_seq_if.sv | 28 ++
 rtl/riscv_v_logic_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/riscv_v_logic_seq_if.sv
// rtl/riscv_v_logic_seq_if.sv - issue/writeback handshake bundle for the vector logic sequencer
interface riscv_v_logic_seq_if #(
  parameter int VLEN = 128,
  parameter int VL_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [VLEN-1:0] vs1;
  logic [VLEN-1:0] vs2;
  logic [VLEN-1:0] vd_old;
  logic [VL_W-1:0] vl;
  logic            flush;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [VLEN-1:0] vd;

  modport master (
    output in_valid, op, vs1, vs2, vd_old, vl, flush, out_ready,
    input  in_ready, busy, out_valid, vd
  );

  modport slave (
    input  in_valid, op, vs1, vs2, vd_old, vl, flush, out_ready,
    output in_ready, busy, out_valid, vd
  );
endinterface

// File: rtl/riscv_v_logic_seq.sv
// rtl/riscv_v_logic_seq.sv - chunked vand/vor/vxor/vmv sequencer with vl tail-undisturbed merge
module riscv_v_logic_seq #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  riscv_v_logic_seq_if.slave bus
);
  localparam int NUM_CHUNKS = VLEN / LANE_WIDTH;
  localparam int VLMAX      = VLEN / 8;
  localparam int VL_W       = $clog2(VLMAX) + 1;
  localparam int BPC        = LANE_WIDTH / 8;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [VLEN-1:0] vs1_q, vs1_d;
  logic [VLEN-1:0] vs2_q, vs2_d;
  logic [VLEN-1:0] old_q, old_d;
  logic [VLEN-1:0] vd_q, vd_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            out_valid_q, out_valid_d;

  logic [LANE_WIDTH-1:0] lane_a, lane_b, lane_old, lane_res, lane_out;
  int                    lane_base;

  // Bytes at or beyond vl keep the previous destination value (tail-undisturbed).
  always_comb begin
    lane_base = int'(cnt_q) * LANE_WIDTH;
    lane_a    = vs1_q[lane_base +: LANE_WIDTH];
    lane_b    = vs2_q[lane_base +: LANE_WIDTH];
    lane_old  = old_q[lane_base +: LANE_WIDTH];
    case (op_q)
      2'b00:   lane_res = lane_a & lane_b;
      2'b01:   lane_res = lane_a | lane_b;
      2'b10:   lane_res = lane_a ^ lane_b;
      default: lane_res = lane_a;
    endcase
    lane_out = lane_old;
    for (int b = 0; b < BPC; b++) begin
      if (int'(cnt_q) * BPC + b < int'(vl_q)) begin
        lane_out[b*8 +: 8] = lane_res[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    vs1_d       = vs1_q;
    vs2_d       = vs2_q;
    old_d       = old_q;
    vl_d        = vl_q;
    vd_d        = vd_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;

    if (bus.flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      busy_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_d    = S_BUSY;
            cnt_d      = '0;
            op_d       = bus.op;
            vs1_d      = bus.vs1;
            vs2_d      = bus.vs2;
            old_d      = bus.vd_old;
            vl_d       = (bus.vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : bus.vl;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
          end
        end
        S_BUSY: begin
          vd_d[lane_base +: LANE_WIDTH] = lane_out;
          if (cnt_q == CNT_W'(NUM_CHUNKS - 1)) begin
            state_d     = S_DONE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      old_q       <= '0;
      vl_q        <= '0;
      vd_q        <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      old_q       <= old_d;
      vl_q        <= vl_d;
      vd_q        <= vd_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.vd        = vd_q;
endmodule
